// File: rtl/core_pipe_pkg.sv
// Shared helpers for the pipeline backbone and hazard logic: occupancy sizing and popcount.
package core_pipe_pkg;

  localparam int POP_MAX = 256;

  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  // Callers zero-extend their valid vector to POP_MAX bits.
  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/core_pipe_stage.sv
// One valid/ready register stage, 1 cycle; SKID=1 gives a registered ready backed by a skid entry,
// SKID=0 a single entry with combinational ready. Flush empties the stage and drops any arriving payload.
module core_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             flush,
  input  logic             prev_valid,
  output logic             prev_ready,
  input  logic [WIDTH-1:0] prev_data,
  output logic             next_valid,
  input  logic             next_ready,
  output logic [WIDTH-1:0] next_data,
  output logic             main_valid,
  output logic             skid_valid,
  output logic [WIDTH-1:0] main_data
);

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;

  assign next_valid = main_vld_q & ~flush;
  assign next_data  = main_dat_q;
  assign main_valid = main_vld_q;
  assign main_data  = main_dat_q;

  if (SKID != 0) begin : g_skid
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             up_xfer;

    assign prev_ready = ~skid_vld_q;
    assign up_xfer    = prev_valid & ~skid_vld_q;
    assign skid_valid = skid_vld_q;

    always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (!main_vld_q || next_ready) begin
        // Skid holds the older item, so it refills main first.
        if (skid_vld_q) begin
          main_vld_d = 1'b1;
          main_dat_d = skid_dat_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = up_xfer;
          if (up_xfer) main_dat_d = prev_data;
        end
      end else if (up_xfer) begin
        skid_vld_d = 1'b1;
        skid_dat_d = prev_data;
      end
      if (flush) begin
        main_vld_d = 1'b0;
        skid_vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        skid_vld_q <= 1'b0;
        skid_dat_q <= '0;
      end else begin
        skid_vld_q <= skid_vld_d;
        skid_dat_q <= skid_dat_d;
      end
    end
  end else begin : g_flat
    assign prev_ready = ~main_vld_q | next_ready;
    assign skid_valid = 1'b0;

    always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      if (!main_vld_q || next_ready) begin
        main_vld_d = prev_valid;
        if (prev_valid) main_dat_d = prev_data;
      end
      if (flush) main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
    end
  end

endmodule

// File: rtl/core_pipe_chain.sv
// STAGES-deep valid/ready backbone (latency STAGES cycles) with per-stage flush and occupancy readout;
// back-pressure ripples stage by stage (SKID=1, registered) or combinationally (SKID=0).
module core_pipe_chain
  import core_pipe_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int WIDTH  = 32,
  parameter int SKID   = 1
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [STAGES-1:0]            flush_mask,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic [occ_width(STAGES)-1:0] occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] skid_vld;

  // Per-stage link wires live in each generate block so the ready chain has no self-dependent vector.
  for (genvar g = 0; g < STAGES; g++) begin : g_st
    logic             up_vld, up_rdy, dn_vld, dn_rdy;
    logic [WIDTH-1:0] up_dat, dn_dat;

    if (g == 0) begin : g_first
      assign up_vld   = in_valid;
      assign up_dat   = in_data;
      assign in_ready = up_rdy;
    end else begin : g_mid
      assign up_vld = g_st[g-1].dn_vld;
      assign up_dat = g_st[g-1].dn_dat;
    end

    if (g == STAGES - 1) begin : g_last
      assign dn_rdy    = out_ready;
      assign out_valid = dn_vld;
      assign out_data  = dn_dat;
    end else begin : g_inner
      assign dn_rdy = g_st[g+1].up_rdy;
    end

    core_pipe_stage #(
      .WIDTH (WIDTH),
      .SKID  (SKID)
    ) u_stage (
      .clk        (clk),
      .rest       (rest),
      .flush      (flush_mask[g]),
      .prev_valid (up_vld),
      .prev_ready (up_rdy),
      .prev_data  (up_dat),
      .next_valid (dn_vld),
      .next_ready (dn_rdy),
      .next_data  (dn_dat),
      .main_valid (stage_valid[g]),
      .skid_valid (skid_vld[g]),
      .main_data  (stage_data[g*WIDTH +: WIDTH])
    );
  end

  assign occupancy = OCC_W'(popcount(POP_MAX'({skid_vld, stage_valid})));

endmodule

// File: tb/tb_core_pipe_chain.sv
// Directed bench for core_pipe_chain: one SKID=1 and one SKID=0 instance, scoreboard-checked outputs.
module tb_core_pipe_chain;

  localparam int STAGES = 5;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_data [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data [2];
  logic [4:0]  flush_mask [2];
  logic [4:0]  stage_valid [2];
  logic [159:0] stage_data [2];
  logic [3:0]  occupancy [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt [2];
  bit          lat_chk [2];
  bit          occ_chk [2];
  logic [31:0] cyc = 0;

  core_pipe_chain #(.STAGES(5), .WIDTH(32), .SKID(1)) dut_skid (
    .clk(clk), .rest(rest),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .flush_mask(flush_mask[0]), .stage_valid(stage_valid[0]),
    .stage_data(stage_data[0]), .occupancy(occupancy[0])
  );

  core_pipe_chain #(.STAGES(5), .WIDTH(32), .SKID(0)) dut_flat (
    .clk(clk), .rest(rest),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .flush_mask(flush_mask[1]), .stage_valid(stage_valid[1]),
    .stage_data(stage_data[1]), .occupancy(occupancy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  // Offer one item; called and returns at posedge+1.
  task automatic send(input int u, input logic [31:0] d, input bit keep);
    int   n;
    exp_t e;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", in_ready[u] == 1'b1, 64'(in_ready[u]), 1);
    if (in_ready[u]) begin
      acc_cnt[u]++;
      if (keep) begin
        e.d   = d;
        e.cyc = cyc;
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic drain(input int u, input string name);
    for (int i = 0; i < 100 && qsize(u) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk(name, qsize(u) == 0, 64'(qsize(u)), 0);
  endtask

  always @(negedge clk) begin
    if (!rest) begin
      for (int u = 0; u < 2; u++) begin
        exp_t e;
        bit   have;
        if (occ_chk[u]) chk("occ_max", occupancy[u] <= 4'd5, 64'(occupancy[u]), 5);
        if (out_valid[u] && out_ready[u]) begin
          have = (qsize(u) != 0);
          chk("out_unexpected", have, 64'(out_data[u]), 0);
          if (have) begin
            if (u == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk((u == 0) ? "out_data_skid" : "out_data_flat", out_data[u] == e.d, 64'(out_data[u]), 64'(e.d));
            if (lat_chk[u]) chk("latency", (cyc - e.cyc) == STAGES, 64'(cyc - e.cyc), STAGES);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; out_ready[u] = 1'b1; flush_mask[u] = '0;
      acc_cnt[u] = 0; lat_chk[u] = 1'b0; occ_chk[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_out_valid", out_valid[u] == 1'b0, 64'(out_valid[u]), 0);
      chk("rst_out_data", out_data[u] == 32'h0, 64'(out_data[u]), 0);
      chk("rst_stage_valid", stage_valid[u] == 5'h0, 64'(stage_valid[u]), 0);
      chk("rst_stage_data", stage_data[u] == 160'h0, 64'(stage_data[u]), 0);
      chk("rst_occupancy", occupancy[u] == 4'd0, 64'(occupancy[u]), 0);
      chk("rst_in_ready", in_ready[u] == 1'b1, 64'(in_ready[u]), 1);
    end
    @(posedge clk); #1 rest = 1'b0;

    // Free-flowing stream: 5-cycle latency, one per cycle, never more than 5 stored.
    lat_chk[0] = 1'b1; occ_chk[0] = 1'b1;
    for (int i = 1; i <= 16; i++) send(0, 32'(i), 1'b1);
    drain(0, "t1_drain");
    lat_chk[0] = 1'b0; occ_chk[0] = 1'b0;

    // Back-pressure fills main and skid entries: exactly 10 accepts.
    out_ready[0] = 1'b0; acc_cnt[0] = 0;
    fork
      begin
        for (int i = 1; i <= 16; i++) send(0, 32'(i), 1'b1);
      end
      begin
        repeat (12) @(negedge clk);
        chk("t2_accepts", acc_cnt[0] == 10, 64'(acc_cnt[0]), 10);
        chk("t2_in_ready", in_ready[0] == 1'b0, 64'(in_ready[0]), 0);
        chk("t2_occupancy", occupancy[0] == 4'd10, 64'(occupancy[0]), 10);
        @(posedge clk); #1 out_ready[0] = 1'b1;
        @(negedge clk);
        chk("t2_full_in_out", in_ready[0] == 1'b0, 64'(in_ready[0]), 0);
      end
    join
    drain(0, "t2_drain");

    // Flush stages 0 and 1 holding 0x0A / 0x0B.
    send(0, 32'h30, 1'b1); send(0, 32'h31, 1'b1);
    send(0, 32'h0B, 1'b0); send(0, 32'h0A, 1'b0);
    flush_mask[0] = 5'b00011;
    @(negedge clk);
    chk("t3_pre_valid", stage_valid[0] == 5'b01111, 64'(stage_valid[0]), 64'h0F);
    chk("t3_pre_occ", occupancy[0] == 4'd4, 64'(occupancy[0]), 4);
    @(posedge clk); #1 flush_mask[0] = 5'b00000;
    @(negedge clk);
    chk("t3_post_valid", stage_valid[0] == 5'b11000, 64'(stage_valid[0]), 64'h18);
    chk("t3_post_occ", occupancy[0] == 4'd2, 64'(occupancy[0]), 2);
    @(posedge clk); #1;
    send(0, 32'h32, 1'b1); send(0, 32'h33, 1'b1);
    drain(0, "t3_drain");

    // Flush stage 1 holding 0x0C while a new item enters stage 0.
    send(0, 32'h0C, 1'b0);
    @(negedge clk);
    chk("t4_pre_valid", stage_valid[0] == 5'b00001, 64'(stage_valid[0]), 1);
    @(posedge clk); #1 flush_mask[0] = 5'b00010;
    send(0, 32'h34, 1'b1);
    flush_mask[0] = 5'b00000;
    @(negedge clk);
    chk("t4_flush_valid", stage_valid[0] == 5'b00001, 64'(stage_valid[0]), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_moved_valid", stage_valid[0] == 5'b00010, 64'(stage_valid[0]), 2);
    chk("t4_moved_data", stage_data[0][63:32] == 32'h34, 64'(stage_data[0][63:32]), 64'h34);
    @(posedge clk); #1;
    drain(0, "t4_drain");

    // Asynchronous reset with a back-pressured pipe, then a fresh stream.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 32'(32'h40 + i), 1'b0);
    @(negedge clk);
    chk("t5_pre_occ", occupancy[0] == 4'd8, 64'(occupancy[0]), 8);
    chk("t5_pre_out_valid", out_valid[0] == 1'b1, 64'(out_valid[0]), 1);
    @(posedge clk); #3 rest = 1'b1;
    #1;
    chk("t5_rst_out_valid", out_valid[0] == 1'b0, 64'(out_valid[0]), 0);
    chk("t5_rst_occ", occupancy[0] == 4'd0, 64'(occupancy[0]), 0);
    chk("t5_rst_in_ready", in_ready[0] == 1'b1, 64'(in_ready[0]), 1);
    chk("t5_rst_stage_valid", stage_valid[0] == 5'h0, 64'(stage_valid[0]), 0);
    @(posedge clk); #1 rest = 1'b0; out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) send(0, 32'(32'h20 + i), 1'b1);
    drain(0, "t5_drain");

    // Single-entry chain: 5 accepts under back-pressure, then toggled out_ready.
    out_ready[1] = 1'b0; acc_cnt[1] = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(1, 32'(32'h50 + i), 1'b1);
      end
      begin
        repeat (7) @(negedge clk);
        chk("t6_accepts", acc_cnt[1] == 5, 64'(acc_cnt[1]), 5);
        chk("t6_in_ready", in_ready[1] == 1'b0, 64'(in_ready[1]), 0);
        chk("t6_occupancy", occupancy[1] == 4'd5, 64'(occupancy[1]), 5);
        @(posedge clk); #1 out_ready[1] = 1'b1;
        @(negedge clk);
        chk("t6_ready_passthru", in_ready[1] == 1'b1, 64'(in_ready[1]), 1);
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1 out_ready[1] = ~out_ready[1];
        end
        out_ready[1] = 1'b1;
      end
    join
    drain(1, "t6_drain");

    lat_chk[1] = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 32'(32'h60 + i), 1'b1);
    drain(1, "t7_drain");
    lat_chk[1] = 1'b0;

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_pipe_chain.md
# core_pipe_chain

Parametrised valid/ready pipeline backbone carrying a WIDTH-bit payload through STAGES register stages. It has per-stage flush, optional skid buffering and an occupancy/status readout. It generalises the fixed IF→ID→EX→MA→WB handshake chain of the core. The next-generation core uses it to build stage-to-stage transport, with branch/exception flush and hazard visibility handled in one place.

## Interface
- STAGES, 5: number of pipeline stages (≥1); stage 0 is nearest the input.
- WIDTH, 32: payload width in bits.
- SKID, 1: 1 = each stage has a main and a skid entry and a registered ready; 0 = single entry per stage with combinational ready.
- clk  input  1  clock; all state updates on the rising edge.
- rest  input  1  reset; asynchronous, active-high.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  WIDTH  payload.
- out_valid  output  1  last stage presents out_data.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload from the last stage.
- flush_mask  input  STAGES  bit i set: kill all contents of stage i this cycle.
- stage_valid  output  STAGES  registered main-entry valid of each stage, for hazard logic.
- stage_data  output  STAGES*WIDTH  main-entry payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- occupancy  output  $clog2(2*STAGES+1)  number of valid entries, main plus skid.

## Operation
- A transfer occurs when valid and ready are both high at a clock edge. Every accepted payload leaves out_data exactly once, in order, unless it is flushed.
- SKID=1 stage:
  - ready_to_prev = !skid_valid, registered.
  - When the main entry is empty or downstream is ready, the main entry loads from skid if skid is valid, otherwise from the upstream input.
  - When the main entry is valid, downstream is not ready, and an upstream transfer occurs, the payload goes to skid.
- SKID=0 stage: ready_to_prev = !main_valid | ready_from_next. The ready path is combinational through the whole chain.
- Flush of stage i:
  - The valid that stage i offers downstream is masked to 0 in that cycle, so nothing passes from stage i to stage i+1.
  - After the edge, stage i is empty (main and skid), including any payload that entered from stage i−1 in that cycle.
  - The upstream handshake still completes, so that payload is dropped.
  - Stages without a flush bit are unaffected.
- flush_mask[STAGES-1] masks out_valid combinationally.
- Payload registers load only on a transfer; their contents are don't-care while the entry is invalid.
- occupancy is the combinational popcount of all registered valid bits. Maximum is 2*STAGES (SKID=1) or STAGES (SKID=0).

## Timing
- Reset values: every valid is 0, all payload registers are 0, out_valid=0, out_data=0, stage_valid=0, stage_data=0, occupancy=0, in_ready=1. Reset takes effect asynchronously, and an in-flight stream is simply discarded.
- Latency: an item accepted at edge n is offered on out_valid at edge n+STAGES, i.e. STAGES cycles with no back-pressure.
- Throughput: one item per cycle in both modes under continuous out_ready.
- SKID=1:
  - in_ready falls the cycle after stage 0's skid fills.
  - With out_ready held low, in_ready goes low once 2*STAGES items are stored.
  - Deasserting out_ready costs no bubbles; on reassertion, output resumes the same cycle.
- SKID=0: in_ready falls in the same cycle as out_ready when all stages are full.
- Simultaneous events:
  - Flush plus an upstream transfer into the same stage: the payload is dropped.
  - Flush of stage i plus its own downstream transfer: no transfer happens.
  - Input and output in the same cycle with a full chain: SKID=0 accepts; SKID=1 accepts only if stage 0's skid is empty.
- flush_mask is sampled every cycle and needs no handshake.

## Structure
- core_pipe_pkg holds function popcount(logic [] v) and a localparam function for the occupancy width; it is shared with the future hazard unit.
- Sub-module core_pipe_stage (parameters WIDTH and SKID; ports clk, rest, flush, prev/next valid/ready/data, main_valid, skid_valid, main_data).
- core_pipe_chain is a generate loop of STAGES core_pipe_stage instances plus the occupancy popcount.

## Test plan
- STAGES=5, WIDTH=32, SKID=1, out_ready=1; stream 0x01..0x10 on consecutive cycles → 0x01 appears at out 5 cycles after its accept, then one item per cycle in order, and occupancy never exceeds 5.
- Same configuration, continuous input, out_ready low for 12 cycles → in_ready low after exactly 10 accepts, occupancy=10. On release, outputs are 0x01..0x10 with no loss or duplication.
- Stages 0 and 1 hold 0xA and 0xB; pulse flush_mask=5'b00011 for one cycle → 0xA and 0xB never appear on out, occupancy drops by 2 at the next edge, and later items are unaffected.
- Stage 1 holds 0xC and stage 2 is ready; assert flush_mask[1] → stage 2 stays empty, 0xC is never output, and stage 0's item moves into stage 1 as usual.
- Full pipe with back-pressure; assert rest mid-cycle → out_valid=0, occupancy=0, in_ready=1 immediately. After release, a new stream 0x20.. emerges correctly.
- SKID=0, out_ready low → in_ready low after 5 accepts, occupancy=5. Toggle out_ready every cycle → order is preserved with no drops.
